// File: rtl/flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flag_ctrl
// Purpose  : Owns the architectural 8086 FLAGS register. Arbitrates ALU status
//            updates, flag-control ops, POPF loads and interrupt entry onto a
//            single registered FLAGS value, and sequences interrupt entry
//            (snapshot -> push to stack unit -> clear IF/TF -> acknowledge).
// Revision : 1.0  initial release
// ============================================================================
module flag_ctrl #(
  parameter logic [15:0] FLAG_MASK = 16'h0FD5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [15:0] alu_status,
  input  logic [8:0]  alu_mask,
  input  logic        fop_valid,
  input  logic [2:0]  fop_code,
  input  logic        popf_valid,
  input  logic [15:0] popf_data,
  input  logic        int_req,
  output logic        int_ack,
  output logic        push_valid,
  output logic [15:0] push_data,
  input  logic        push_ready,
  output logic [15:0] flags,
  output logic        busy,
  output logic        wr_conflict
);

  // FLAGS bit positions
  localparam int CF_BIT = 0;
  localparam int TF_BIT = 8;
  localparam int IF_BIT = 9;
  localparam int DF_BIT = 10;

  // Flag-control op encodings
  localparam logic [2:0] FOP_CLC = 3'd0;
  localparam logic [2:0] FOP_STC = 3'd1;
  localparam logic [2:0] FOP_CMC = 3'd2;
  localparam logic [2:0] FOP_CLD = 3'd3;
  localparam logic [2:0] FOP_STD = 3'd4;
  localparam logic [2:0] FOP_CLI = 3'd5;
  localparam logic [2:0] FOP_STI = 3'd6;
  localparam logic [2:0] FOP_NOP = 3'd7;

  // Interrupt-entry sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SAVE  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] flags_reg;
  logic [15:0] flags_wr;
  logic [15:0] flags_next;
  logic [15:0] alu_en;
  logic [15:0] alu_val;
  logic        fop_write;
  logic        take_int;
  logic [1:0]  src_count;
  logic        conflict_next;
  logic        unused_status_bits;

  // ALU status bits [12:4] and mask bits [8:0] scattered onto FLAGS positions:
  // OF->11 DF->10 IF->9 TF->8 SF->7 ZF->6 AF->4 PF->2 CF->0
  assign alu_en  = {4'b0000,
                    alu_mask[8], alu_mask[7], alu_mask[6], alu_mask[5],
                    alu_mask[4], alu_mask[3], 1'b0, alu_mask[2],
                    1'b0, alu_mask[1], 1'b0, alu_mask[0]};
  assign alu_val = {4'b0000,
                    alu_status[12], alu_status[11], alu_status[10], alu_status[9],
                    alu_status[8], alu_status[7], 1'b0, alu_status[6],
                    1'b0, alu_status[5], 1'b0, alu_status[4]};

  // Status bits outside [12:4] carry no flag meaning
  assign unused_status_bits = ^{alu_status[15:13], alu_status[3:0]};

  // A NOP op is not a write, so it neither wins arbitration nor counts as a source
  assign fop_write = fop_valid && (fop_code != FOP_NOP);

  // Interrupt entry is only taken while idle and with IF set
  assign take_int  = int_req && flags_reg[IF_BIT];

  assign src_count = {1'b0, popf_valid} + {1'b0, fop_write} + {1'b0, alu_valid};

  // State register for the interrupt-entry sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: SAVE waits for the stack unit, CLEAR and ACK last one cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (take_int)   state_next = ST_SAVE;
      ST_SAVE:  if (push_ready) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_ACK;
      ST_ACK:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Sequencer outputs decoded from the current state
  always_comb begin
    busy       = (state != ST_IDLE);
    push_valid = (state == ST_SAVE);
    int_ack    = (state == ST_ACK);
  end

  // Write arbitration: interrupt entry > popf > fop > alu, only while idle
  always_comb begin
    flags_wr      = flags_reg;
    conflict_next = 1'b0;
    case (state)
      ST_IDLE: begin
        conflict_next = (src_count >= 2'd2);
        if (take_int) begin
          // Entry wins; any same-cycle write is dropped so the snapshot is exact
          flags_wr = flags_reg;
        end else if (popf_valid) begin
          flags_wr = popf_data;
        end else if (fop_write) begin
          case (fop_code)
            FOP_CLC: flags_wr[CF_BIT] = 1'b0;
            FOP_STC: flags_wr[CF_BIT] = 1'b1;
            FOP_CMC: flags_wr[CF_BIT] = ~flags_reg[CF_BIT];
            FOP_CLD: flags_wr[DF_BIT] = 1'b0;
            FOP_STD: flags_wr[DF_BIT] = 1'b1;
            FOP_CLI: flags_wr[IF_BIT] = 1'b0;
            FOP_STI: flags_wr[IF_BIT] = 1'b1;
            default: flags_wr = flags_reg;
          endcase
        end else if (alu_valid) begin
          flags_wr = (flags_reg & ~alu_en) | (alu_val & alu_en);
        end
      end
      ST_CLEAR: begin
        flags_wr[IF_BIT] = 1'b0;
        flags_wr[TF_BIT] = 1'b0;
      end
      default: flags_wr = flags_reg;
    endcase
    flags_next = flags_wr & FLAG_MASK;
  end

  // FLAGS register and one-cycle conflict pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg   <= 16'h0000;
      wr_conflict <= 1'b0;
    end else begin
      flags_reg   <= flags_next;
      wr_conflict <= conflict_next;
    end
  end

  // Snapshot captured on the entry edge and held stable through SAVE
  always_ff @(posedge clk) begin
    if (reset) begin
      push_data <= 16'h0000;
    end else if ((state == ST_IDLE) && take_int) begin
      push_data <= flags_reg;
    end
  end

  assign flags = flags_reg;

endmodule
`default_nettype wire

// File: tb/tb_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_ctrl
// Purpose  : Self-checking bench for flag_ctrl. A behavioural model predicts
//            every cycle's outputs into a queue; a monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_flag_ctrl;

  localparam logic [15:0] FLAG_MASK = 16'h0FD5;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [15:0] alu_status;
  logic [8:0]  alu_mask;
  logic        fop_valid;
  logic [2:0]  fop_code;
  logic        popf_valid;
  logic [15:0] popf_data;
  logic        int_req;
  logic        int_ack;
  logic        push_valid;
  logic [15:0] push_data;
  logic        push_ready;
  logic [15:0] flags;
  logic        busy;
  logic        wr_conflict;

  flag_ctrl #(.FLAG_MASK(FLAG_MASK)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_status(alu_status), .alu_mask(alu_mask),
    .fop_valid(fop_valid), .fop_code(fop_code),
    .popf_valid(popf_valid), .popf_data(popf_data),
    .int_req(int_req), .int_ack(int_ack),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .flags(flags), .busy(busy), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] flags;
    logic        conf;
    logic        pv;
    logic [15:0] pd;
    logic        ack;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: architectural flags plus progress of an entry
  logic [15:0] m_flags;
  logic [15:0] m_pd;
  logic        m_busy;
  logic        m_saving;
  logic        m_conf;
  int          m_after;     // cycles left in entry after the push is taken
  logic [3:0]  ALU_POS [9] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

  // Predict outputs for the cycle following the current input set
  task automatic model_step();
    exp_t e;
    int   n;
    logic fop_w;
    fop_w = fop_valid && (fop_code != 3'd7);
    n = int'(popf_valid) + int'(fop_w) + int'(alu_valid);
    if (reset) begin
      m_flags = 16'h0; m_pd = 16'h0; m_busy = 1'b0; m_saving = 1'b0;
      m_after = 0; m_conf = 1'b0;
    end else if (!m_busy) begin
      m_conf = (n >= 2);
      if (int_req && m_flags[9]) begin
        m_busy = 1'b1; m_saving = 1'b1; m_pd = m_flags;
      end else if (popf_valid) begin
        m_flags = popf_data;
      end else if (fop_w) begin
        case (fop_code)
          3'd0: m_flags[0]  = 1'b0;
          3'd1: m_flags[0]  = 1'b1;
          3'd2: m_flags[0]  = ~m_flags[0];
          3'd3: m_flags[10] = 1'b0;
          3'd4: m_flags[10] = 1'b1;
          3'd5: m_flags[9]  = 1'b0;
          3'd6: m_flags[9]  = 1'b1;
          default: ;
        endcase
      end else if (alu_valid) begin
        for (int i = 0; i < 9; i++)
          if (alu_mask[i]) m_flags[ALU_POS[i]] = alu_status[i+4];
      end
      m_flags = m_flags & FLAG_MASK;
    end else begin
      m_conf = 1'b0;
      if (m_saving) begin
        if (push_ready) begin m_saving = 1'b0; m_after = 2; end
      end else if (m_after == 2) begin
        m_flags[9] = 1'b0; m_flags[8] = 1'b0; m_after = 1;
      end else begin
        m_busy = 1'b0; m_after = 0;
      end
    end
    e.flags = m_flags; e.conf = m_conf; e.pv = m_saving; e.pd = m_pd;
    e.ack = (m_after == 1); e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  // Issue the current inputs for one clock and record the prediction
  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    reset = 1'b0; alu_valid = 1'b0; alu_status = 16'h0; alu_mask = 9'h0;
    fop_valid = 1'b0; fop_code = 3'd7; popf_valid = 1'b0; popf_data = 16'h0;
    int_req = 1'b0; push_ready = 1'b1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, expv);
    end
  endtask

  // Monitor: compare every cycle's outputs with the queued prediction
  always @(posedge clk) begin
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow at %0t", $time);
    end else begin
      mon_e = exp_q.pop_front();
      if ({flags, wr_conflict, push_valid, push_data, int_ack, busy} !== mon_e) begin
        n_fail++;
        $display("FAIL cycle_outputs at %0t: actual flags=%h conf=%b pv=%b pd=%h ack=%b busy=%b required flags=%h conf=%b pv=%b pd=%h ack=%b busy=%b",
                 $time, flags, wr_conflict, push_valid, push_data, int_ack, busy,
                 mon_e.flags, mon_e.conf, mon_e.pv, mon_e.pd, mon_e.ack, mon_e.busy);
      end
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    cycle();
    check("reset_flags", flags, 16'h0000);
    check("reset_busy", {15'h0, busy}, 16'h0);
    check("reset_push_valid", {15'h0, push_valid}, 16'h0);
    check("reset_push_data", push_data, 16'h0000);

    // T1: popf of all ones keeps only implemented bits
    clear_inputs(); popf_valid = 1'b1; popf_data = 16'hFFFF; cycle();
    check("t1_popf_mask", flags, 16'h0FD5);

    // T2: masked ALU update of OF and CF
    clear_inputs(); reset = 1'b1; cycle();
    clear_inputs(); alu_valid = 1'b1; alu_status = 16'h1FF0; alu_mask = 9'h101; cycle();
    check("t2_alu_of_cf", flags, 16'h0801);

    // T3: CMC, STD, CLI
    clear_inputs(); popf_valid = 1'b1; popf_data = 16'h0001; cycle();
    clear_inputs(); fop_valid = 1'b1; fop_code = 3'd2; cycle();
    check("t3_cmc", flags, 16'h0000);
    fop_code = 3'd4; cycle();
    check("t3_std", flags, 16'h0400);
    fop_code = 3'd5; cycle();
    check("t3_cli", flags, 16'h0400);

    // T4: three sources at once, popf wins and conflict pulses once
    clear_inputs(); popf_valid = 1'b1; popf_data = 16'h0200;
    fop_valid = 1'b1; fop_code = 3'd1; alu_valid = 1'b1; alu_status = 16'hFFF0; alu_mask = 9'h1FF;
    cycle();
    check("t4_popf_wins", flags, 16'h0200);
    check("t4_conflict", {15'h0, wr_conflict}, 16'h1);
    clear_inputs(); cycle();
    check("t4_conflict_pulse", {15'h0, wr_conflict}, 16'h0);

    // T5: interrupt entry with a stalled stack unit, ALU writes ignored while busy
    clear_inputs(); popf_valid = 1'b1; popf_data = 16'h0341; cycle();
    clear_inputs(); int_req = 1'b1; push_ready = 1'b0;
    alu_valid = 1'b1; alu_status = 16'h0000; alu_mask = 9'h1FF;
    cycle();
    check("t5_save_push_valid", {15'h0, push_valid}, 16'h1);
    check("t5_save_push_data", push_data, 16'h0341);
    cycle();
    cycle();
    check("t5_stall_push_data", push_data, 16'h0341);
    check("t5_stall_flags", flags, 16'h0341);
    push_ready = 1'b1; cycle();
    check("t5_clear_ack_low", {15'h0, int_ack}, 16'h0);
    cycle();
    check("t5_ack_flags", flags, 16'h0041);
    check("t5_ack_pulse", {15'h0, int_ack}, 16'h1);
    cycle();
    check("t5_ack_once", {15'h0, int_ack}, 16'h0);
    check("t5_idle_flags", flags, 16'h0041);
    alu_valid = 1'b0; cycle();
    check("t5_no_reentry", {15'h0, busy}, 16'h0);

    // T6: request with IF clear is ignored; reset aborts an entry
    clear_inputs(); popf_valid = 1'b1; popf_data = 16'h0000; cycle();
    clear_inputs(); int_req = 1'b1; cycle();
    check("t6_if_clear_ignored", {15'h0, push_valid}, 16'h0);
    clear_inputs(); popf_valid = 1'b1; popf_data = 16'h0200; cycle();
    clear_inputs(); int_req = 1'b1; push_ready = 1'b0; cycle();
    check("t6_in_save", {15'h0, push_valid}, 16'h1);
    reset = 1'b1; cycle();
    check("t6_reset_push_valid", {15'h0, push_valid}, 16'h0);
    check("t6_reset_flags", flags, 16'h0000);
    clear_inputs(); cycle();
    check("t6_no_ack", {15'h0, int_ack}, 16'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 99) == 0);
      int_req    = ($urandom_range(0, 3) == 0);
      push_ready = ($urandom_range(0, 1) == 0);
      popf_valid = ($urandom_range(0, 5) == 0);
      popf_data  = 16'($urandom);
      fop_valid  = ($urandom_range(0, 3) == 0);
      fop_code   = 3'($urandom_range(0, 7));
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_status = 16'($urandom);
      alu_mask   = 9'($urandom);
      cycle();
    end
    clear_inputs(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
